// File: rtl/vram_scan_fetch_pkg.sv
// Shared encodings and packing constants for the VRAM scan-out fetch stage.
package vram_scan_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [29:0] VRAM_BASE_DEF = 30'h10000;
  localparam int          PIX_PER_WORD  = 4;
  localparam int          PIX_BITS      = 4;

endpackage

// File: rtl/vram_word_fifo.sv
// Synchronous show-ahead word FIFO with occupancy count and flush; 1-cycle push-to-visible.
// A push into a full FIFO or a pop from an empty one is ignored; flush overrides push and pop.
module vram_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_pop_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [AW:0]   FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_count != FULL_CNT);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/vram_scan_fetch.sv
// Raster-order 4bpp framebuffer fetch + unpack; first pixel 4 edges after frame_start, then 1 px/accepted cycle.
// Reads stall on FIFO credit when px_ready is low; define VRAM_SCAN_HDOUBLE_EN to present each pixel twice.
module vram_scan_fetch
  import vram_scan_fetch_pkg::*;
#(
  parameter int          H_PIX      = 320,
  parameter int          V_PIX      = 240,
  parameter logic [29:0] VRAM_BASE  = VRAM_BASE_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_frame_start,
  output logic                o_vram_rd,
  output logic [29:0]         o_vram_addr,
  input  logic [31:0]         i_vram_q,
  input  logic                i_px_ready,
  output logic [PIX_BITS-1:0] o_px,
  output logic                o_px_valid,
  output logic                o_frame_done,
  output logic                o_underrun
);

  localparam int WW    = PIX_PER_WORD * PIX_BITS;
  localparam int WORDS = H_PIX * V_PIX / PIX_PER_WORD;
`ifdef VRAM_SCAN_HDOUBLE_EN
  localparam int REPS  = 2;
`else
  localparam int REPS  = 1;
`endif
  localparam int TOTAL = H_PIX * V_PIX * REPS;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int WIW   = $clog2(WORDS + 1);
  localparam int AIW   = $clog2(TOTAL + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIW-1:0]     r_word_idx;
  logic               r_vram_rd;
  logic [29:0]        r_vram_addr;
  logic               r_epoch;
  logic               r_rd_epoch;
  logic               r_ret;
  logic               r_ret_epoch;
  logic [WW-1:0]      r_word;
  logic [1:0]         r_nib;
  logic               r_word_vld;
  logic               r_half;
  logic [AIW-1:0]     r_acc_left;
  logic               r_frame_done;
  logic               r_underrun;

  logic [WW-1:0]      w_fifo_dat;
  logic [CW-1:0]      w_fifo_cnt;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_issue;
  logic               w_last_issue;
  logic               w_px_valid;
  logic               w_accept;
  logic               w_pix_done;
  logic               w_need;
  logic               w_unused;

  // Only the low half of each VRAM word carries pixels.
  assign w_unused = ^i_vram_q[31:WW];

  // One read outstanding at a time; the FIFO credit check covers the returning word.
  assign w_issue      = (r_state == ST_FETCH) && !r_vram_rd && !r_ret &&
                        (w_fifo_cnt < CW'(FIFO_DEPTH)) && !i_frame_start;
  assign w_last_issue = w_issue && (r_word_idx == WIW'(WORDS - 1));

  // Returns tagged with a stale epoch belong to a frame that was restarted.
  assign w_push = r_ret && (r_ret_epoch == r_epoch) && !i_frame_start;

  assign w_px_valid = r_word_vld && (r_acc_left != '0);
  assign w_accept   = i_px_ready && w_px_valid;
`ifdef VRAM_SCAN_HDOUBLE_EN
  assign w_pix_done = w_accept && r_half;
`else
  assign w_pix_done = w_accept;
`endif
  assign w_need = !r_word_vld || (w_pix_done && (r_nib == 2'd3));
  assign w_pop  = w_need && !w_fifo_empty && (r_state != ST_IDLE) && !i_frame_start;

  vram_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WW)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (i_frame_start),
    .i_push     (w_push),
    .i_push_dat (i_vram_q[WW-1:0]),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_count    (w_fifo_cnt),
    .o_empty    (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_frame_start)     w_state_nxt = ST_FETCH;
        else if (w_last_issue) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_frame_start)     w_state_nxt = ST_FETCH;
        else if (r_frame_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_word_idx   <= '0;
      r_vram_rd    <= 1'b0;
      r_vram_addr  <= VRAM_BASE;
      r_epoch      <= 1'b0;
      r_rd_epoch   <= 1'b0;
      r_ret        <= 1'b0;
      r_ret_epoch  <= 1'b0;
      r_word       <= '0;
      r_nib        <= '0;
      r_word_vld   <= 1'b0;
      r_half       <= 1'b0;
      r_acc_left   <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vram_rd   <= w_issue;
      r_ret       <= r_vram_rd;
      r_ret_epoch <= r_rd_epoch;
      if (w_issue) begin
        r_vram_addr <= VRAM_BASE + 30'(r_word_idx);
        r_rd_epoch  <= r_epoch;
        r_word_idx  <= r_word_idx + 1'b1;
      end

      if (i_frame_start) begin
        r_epoch      <= ~r_epoch;
        r_word_idx   <= '0;
        r_word       <= '0;
        r_nib        <= '0;
        r_word_vld   <= 1'b0;
        r_half       <= 1'b0;
        r_acc_left   <= AIW'(TOTAL);
        r_frame_done <= 1'b0;
        r_underrun   <= 1'b0;
      end else begin
        if (i_px_ready && !w_px_valid && (r_state != ST_IDLE) && !r_frame_done) begin
          r_underrun <= 1'b1;
        end

        if (w_pop) begin
          r_word     <= w_fifo_dat;
          r_nib      <= '0;
          r_half     <= 1'b0;
          r_word_vld <= 1'b1;
        end else if (w_pix_done) begin
          r_half <= 1'b0;
          if (r_nib == 2'd3) r_word_vld <= 1'b0;
          else               r_nib      <= r_nib + 1'b1;
        end else if (w_accept) begin
          r_half <= 1'b1;
        end

        if (w_accept) begin
          r_acc_left <= r_acc_left - 1'b1;
          if (r_acc_left == AIW'(1)) begin
            r_frame_done <= 1'b1;
            r_word_vld   <= 1'b0;
          end
        end
      end
    end
  end

  assign o_vram_rd    = r_vram_rd;
  assign o_vram_addr  = r_vram_addr;
  assign o_px         = r_word[r_nib*PIX_BITS +: PIX_BITS];
  assign o_px_valid   = w_px_valid;
  assign o_frame_done = r_frame_done;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_vram_scan_fetch.sv
// Bench for vram_scan_fetch on a reduced frame; pixels and read addresses are checked against a raster model.
module tb_vram_scan_fetch;

  localparam int          H     = 64;
  localparam int          V     = 16;
  localparam int          DEPTH = 8;
  localparam logic [29:0] BASE  = 30'h10000;
  localparam int          WORDS = H * V / 4;
`ifdef VRAM_SCAN_HDOUBLE_EN
  localparam int          REPS  = 2;
`else
  localparam int          REPS  = 1;
`endif
  localparam int          TOTAL = H * V * REPS;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        px_ready;
  logic        vram_rd;
  logic [29:0] vram_addr;
  logic [31:0] vram_q;
  logic [3:0]  px;
  logic        px_valid;
  logic        frame_done;
  logic        underrun;

  logic [15:0] mem [WORDS];
  logic [29:0] rd_log [4096];
  int          rd_total = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vram_scan_fetch #(
    .H_PIX      (H),
    .V_PIX      (V),
    .VRAM_BASE  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_frame_start (frame_start),
    .o_vram_rd     (vram_rd),
    .o_vram_addr   (vram_addr),
    .i_vram_q      (vram_q),
    .i_px_ready    (px_ready),
    .o_px          (px),
    .o_px_valid    (px_valid),
    .o_frame_done  (frame_done),
    .o_underrun    (underrun)
  );

  // RAM port B: data is valid only in the cycle after a sampled read; garbage otherwise.
  always @(posedge clk) begin : ram
    int idx;
    if (vram_rd) begin
      idx = int'(vram_addr) - int'(BASE);
      vram_q <= {16'($urandom), (idx >= 0 && idx < WORDS) ? mem[idx] : 16'hDEAD};
      rd_log[rd_total % 4096] <= vram_addr;
      rd_total <= rd_total + 1;
    end else begin
      vram_q <= $urandom;
    end
  end

  // Accepted cycle k shows pixel k/REPS; pixel p is nibble p%4 of word p/4.
  function automatic logic [3:0] exp_px(input int acc);
    int p;
    logic [15:0] w;
    p = acc / REPS;
    w = mem[p / 4];
    return w[4 * (p % 4) +: 4];
  endfunction

  task automatic pulse_start(input logic ready);
    @(negedge clk);
    px_ready    = ready;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !px_valid; i++) @(negedge clk);
    n_vec++;
    if (px_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wait_valid: px_valid=%b required 1 within 20 cycles", px_valid);
    end
  endtask

  // Consumes a frame from pixel 0; with stop_acc <= TOTAL it returns early at the first
  // cycle past stop_acc with a read strobe out, leaving the frame unfinished.
  task automatic drain(input int pct, input int stop_acc, input int rd0);
    int acc = 0;
    int cyc = 0;
    logic [3:0] e;
    while (acc < TOTAL && cyc < TOTAL * 8 + 200) begin
      if (acc >= stop_acc && vram_rd) return;
      px_ready = ($urandom_range(99) < pct);
      if (px_valid && px_ready) begin
        e = exp_px(acc);
        n_vec++;
        if (px !== e) begin
          n_err++;
          $display("FAIL px[%0d]: got %0h required %0h", acc, px, e);
        end
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    if (stop_acc <= TOTAL) begin
      n_vec++;
      n_err++;
      $display("FAIL restart_point: no read strobe seen after pixel %0d", stop_acc);
      return;
    end
    n_vec++;
    if (acc != TOTAL) begin
      n_err++;
      $display("FAIL pixel_count: got %0d required %0d", acc, TOTAL);
    end
    n_vec++;
    if (frame_done !== 1'b1 || px_valid !== 1'b0) begin
      n_err++;
      $display("FAIL frame_end: frame_done=%b px_valid=%b required 1/0", frame_done, px_valid);
    end
    n_vec++;
    if (rd_total - rd0 != WORDS) begin
      n_err++;
      $display("FAIL read_count: got %0d required %0d", rd_total - rd0, WORDS);
    end
    for (int i = 0; i < WORDS && i < rd_total - rd0; i++) begin
      n_vec++;
      if (rd_log[(rd0 + i) % 4096] !== BASE + 30'(i)) begin
        n_err++;
        $display("FAIL read_addr[%0d]: got %h required %h", i, rd_log[(rd0 + i) % 4096], BASE + 30'(i));
        break;
      end
    end
    px_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1 || px_valid !== 1'b0) begin
      n_err++;
      $display("FAIL frame_hold: frame_done=%b px_valid=%b required 1/0", frame_done, px_valid);
    end
  endtask

  task automatic test_reset();
    bit seen_rd;
    reset       = 1'b1;
    frame_start = 1'b1;
    px_ready    = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (vram_rd !== 1'b0 || vram_addr !== BASE || px !== 4'h0 || px_valid !== 1'b0 ||
        frame_done !== 1'b0 || underrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: rd=%b addr=%h px=%h vld=%b done=%b und=%b required 0/%h/0/0/0/0",
               vram_rd, vram_addr, px, px_valid, frame_done, underrun, BASE);
    end
    reset       = 1'b0;
    frame_start = 1'b0;
    seen_rd     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vram_rd || px_valid || underrun) seen_rd = 1'b1;
    end
    n_vec++;
    if (seen_rd) begin
      n_err++;
      $display("FAIL reset_wins: activity seen after reset+frame_start, required idle");
    end
    px_ready = 1'b0;
  endtask

  task automatic test_latency_underrun();
    int rd0 = rd_total;
    pulse_start(1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (px_valid !== (i == 4)) begin
        n_err++;
        $display("FAIL latency edge %0d: px_valid=%b required %b", i, px_valid, i == 4);
      end
      if (i == 1) begin
        n_vec++;
        if (vram_rd !== 1'b1 || vram_addr !== BASE || underrun !== 1'b1) begin
          n_err++;
          $display("FAIL first_read: rd=%b addr=%h und=%b required 1/%h/1", vram_rd, vram_addr, underrun, BASE);
        end
      end
    end
    drain(100, TOTAL + 1, rd0);
    n_vec++;
    if (underrun !== 1'b1) begin
      n_err++;
      $display("FAIL underrun_sticky: got %b required 1", underrun);
    end
    pulse_start(1'b0);
    n_vec++;
    if (underrun !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL underrun_clear: und=%b done=%b required 0/0", underrun, frame_done);
    end
  endtask

  // Continues the frame started by the previous test: FIFO full plus the unpacker's word.
  task automatic test_backpressure();
    int rd0 = rd_total;
    px_ready = 1'b0;
    repeat (50) @(negedge clk);
    n_vec++;
    if (rd_total - rd0 != DEPTH + 1 || px_valid !== 1'b1 || vram_rd !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure: reads=%0d vld=%b rd=%b required %0d/1/0", rd_total - rd0, px_valid, vram_rd, DEPTH + 1);
    end
    drain(100, TOTAL + 1, rd0);
    n_vec++;
    if (underrun !== 1'b0) begin
      n_err++;
      $display("FAIL bp_underrun: got %b required 0", underrun);
    end
  endtask

  task automatic test_random_ready();
    int rd0;
    pulse_start(1'b0);
    rd0 = rd_total;
    wait_valid();
    drain(60, TOTAL + 1, rd0);
    n_vec++;
    if (underrun !== 1'b0) begin
      n_err++;
      $display("FAIL rand_underrun: got %b required 0", underrun);
    end
  endtask

  task automatic test_restart_midframe();
    int rd0;
    pulse_start(1'b0);
    wait_valid();
    drain(100, 250 * REPS, rd_total);
    px_ready    = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    rd0 = rd_total;
    n_vec++;
    if (px_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_flush: vld=%b done=%b required 0/0", px_valid, frame_done);
    end
    wait_valid();
    drain(100, TOTAL + 1, rd0);
    n_vec++;
    if (underrun !== 1'b0) begin
      n_err++;
      $display("FAIL restart_underrun: got %b required 0", underrun);
    end
  endtask

  initial begin
    mem[0] = 16'h3210;
    for (int i = 1; i < WORDS; i++) mem[i] = 16'($urandom);
    test_reset();
    test_latency_underrun();
    test_backpressure();
    test_random_ready();
    test_restart_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
